// File: rtl/alu_arbiter.sv
// =============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin arbiter sharing one combinational ALU between
//                NREQ requesters. One operation is in flight at a time.
//                Optional statistics (op_count, contention) via ALU_ARB_STAT_EN.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32,
    parameter int IW    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_ctl,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_zero,
    output logic [2:0]            alu_ctl,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    input  logic [WIDTH-1:0]      alu_o,
    input  logic                  alu_zero,
    output logic                  busy
`ifdef ALU_ARB_STAT_EN
    ,
    output logic [15:0]           op_count,
    output logic                  contention
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IW-1:0]     r_rr_ptr;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     w_win;
    logic [IW-1:0]     w_ptr_nxt;
    logic              w_found;
    logic              w_grant;
    logic              w_rsp_hs;
    logic [2:0]        w_sel_ctl;
    logic [WIDTH-1:0]  w_sel_a;
    logic [WIDTH-1:0]  w_sel_b;
    int                w_best;
    int                w_dist;

    // Winner is the valid requester with the smallest circular distance from rr_ptr.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_best  = NREQ;
        w_dist  = 0;
        for (int j = 0; j < NREQ; j++) begin
            if (req_valid[j]) begin
                w_dist = (j >= int'(r_rr_ptr)) ? (j - int'(r_rr_ptr))
                                               : (j + NREQ - int'(r_rr_ptr));
                if (w_dist < w_best) begin
                    w_best  = w_dist;
                    w_win   = IW'(j);
                    w_found = 1'b1;
                end
            end
        end
    end

    assign w_grant   = (r_state == ST_IDLE) && w_found;
    assign w_ptr_nxt = (w_win == IW'(NREQ - 1)) ? '0 : (w_win + IW'(1));
    assign w_rsp_hs  = |(rsp_valid & rsp_ready);
    assign busy      = (r_state != ST_IDLE);

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        w_sel_ctl = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_grant && (w_win == IW'(i));
            rsp_valid[i] = (r_state == ST_RESP) && (r_owner == IW'(i));
            if (w_win == IW'(i)) begin
                w_sel_ctl = req_ctl[3*i +: 3];
                w_sel_a   = req_a[WIDTH*i +: WIDTH];
                w_sel_b   = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_found)  w_state_nxt = ST_EXEC;
            ST_EXEC:               w_state_nxt = ST_RESP;
            ST_RESP: if (w_rsp_hs) w_state_nxt = ST_IDLE;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    // ALU operands only change on a grant, so they hold their last value outside EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            alu_ctl  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
        end else begin
            if (w_grant) begin
                alu_ctl  <= w_sel_ctl;
                alu_a    <= w_sel_a;
                alu_b    <= w_sel_b;
                r_owner  <= w_win;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == ST_EXEC) begin
                rsp_data <= alu_o;
                rsp_zero <= alu_zero;
            end
        end
    end

`ifdef ALU_ARB_STAT_EN
    logic w_multi;

    assign w_multi = |(req_valid & (req_valid - NREQ'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count   <= '0;
            contention <= 1'b0;
        end else begin
            contention <= w_grant && w_multi;
            if (w_rsp_hs && (op_count != 16'hFFFF)) begin
                op_count <= op_count + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// =============================================================================
//  Module      : tb_alu_arbiter
//  Description : Scoreboard bench for alu_arbiter (NREQ=2 and NREQ=3 instances).
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_alu_arbiter;

    typedef struct {
        logic [7:0]  vld;
        logic [31:0] data;
        logic        zero;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_grant2 = 0, n_rsp2 = 0, n_grant3 = 0, n_rsp3 = 0;

    logic [7:0] gq2[$];
    logic [7:0] gq3[$];
    rsp_t       rq2[$];
    rsp_t       rq3[$];

    // ---------------- NREQ=2 instance ----------------
    logic [1:0]  req_valid2, req_ready2, rsp_valid2, rsp_ready2;
    logic [5:0]  ctl2;
    logic [63:0] a2, b2;
    logic [31:0] rsp_data2, alu_a2, alu_b2, alu_o2;
    logic        rsp_zero2, alu_zero2, busy2;
    logic [2:0]  alu_ctl2;
`ifdef ALU_ARB_STAT_EN
    logic [15:0] op_count2;
    logic        contention2;
`endif

    // ---------------- NREQ=3 instance ----------------
    logic [2:0]  req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [8:0]  ctl3;
    logic [95:0] a3, b3;
    logic [31:0] rsp_data3, alu_a3, alu_b3, alu_o3;
    logic        rsp_zero3, alu_zero3, busy3;
    logic [2:0]  alu_ctl3;
`ifdef ALU_ARB_STAT_EN
    logic [15:0] op_count3;
    logic        contention3;
`endif

    function automatic logic [31:0] alu_f(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return {31'd0, ($signed(a) < $signed(b))};
        endcase
    endfunction

    assign alu_o2    = alu_f(alu_ctl2, alu_a2, alu_b2);
    assign alu_zero2 = (alu_o2 == 32'd0);
    assign alu_o3    = alu_f(alu_ctl3, alu_a3, alu_b3);
    assign alu_zero3 = (alu_o3 == 32'd0);

    alu_arbiter #(.NREQ(2), .WIDTH(32), .IW(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_ctl(ctl2), .req_a(a2), .req_b(b2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_data(rsp_data2), .rsp_zero(rsp_zero2),
        .alu_ctl(alu_ctl2), .alu_a(alu_a2), .alu_b(alu_b2),
        .alu_o(alu_o2), .alu_zero(alu_zero2), .busy(busy2)
`ifdef ALU_ARB_STAT_EN
        , .op_count(op_count2), .contention(contention2)
`endif
    );

    alu_arbiter #(.NREQ(3), .WIDTH(32), .IW(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_ctl(ctl3), .req_a(a3), .req_b(b3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .rsp_zero(rsp_zero3),
        .alu_ctl(alu_ctl3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_o(alu_o3), .alu_zero(alu_zero3), .busy(busy3)
`ifdef ALU_ARB_STAT_EN
        , .op_count(op_count3), .contention(contention3)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: sample on the falling edge, pop expectations on grants and handshakes.
    always @(negedge clk) begin : mon2
        rsp_t e;
        if (rst_n) begin
            if (req_ready2 != 2'b00) begin
                n_grant2++;
                if (gq2.size() == 0) chk("grant2_unexpected", 64'(req_ready2), 64'd0);
                else                 chk("grant2", 64'(req_ready2), 64'(gq2.pop_front()));
            end
            if ((rsp_valid2 & rsp_ready2) != 2'b00) begin
                n_rsp2++;
                if (rq2.size() == 0) chk("rsp2_unexpected", 64'(rsp_valid2), 64'd0);
                else begin
                    e = rq2.pop_front();
                    chk("rsp2_owner", 64'(rsp_valid2), 64'(e.vld));
                    chk("rsp2_data",  64'(rsp_data2),  64'(e.data));
                    chk("rsp2_zero",  64'(rsp_zero2),  64'(e.zero));
                end
            end
        end
    end

    always @(negedge clk) begin : mon3
        rsp_t e;
        if (rst_n) begin
            if (req_ready3 != 3'b000) begin
                n_grant3++;
                if (gq3.size() == 0) chk("grant3_unexpected", 64'(req_ready3), 64'd0);
                else                 chk("grant3", 64'(req_ready3), 64'(gq3.pop_front()));
            end
            if ((rsp_valid3 & rsp_ready3) != 3'b000) begin
                n_rsp3++;
                if (rq3.size() == 0) chk("rsp3_unexpected", 64'(rsp_valid3), 64'd0);
                else begin
                    e = rq3.pop_front();
                    chk("rsp3_owner", 64'(rsp_valid3), 64'(e.vld));
                    chk("rsp3_data",  64'(rsp_data3),  64'(e.data));
                    chk("rsp3_zero",  64'(rsp_zero3),  64'(e.zero));
                end
            end
        end
    end

    // Returns on the rising edge that completes the awaited event.
    task automatic wait_grants(input int sel, input int target);
        int cyc = 0;
        while (((sel == 0) ? n_grant2 : n_grant3) < target && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 200) chk("grant_wait_timeout", 64'(target), 64'((sel == 0) ? n_grant2 : n_grant3));
    endtask

    task automatic wait_rsps(input int sel, input int target);
        int cyc = 0;
        while (((sel == 0) ? n_rsp2 : n_rsp3) < target && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 200) chk("rsp_wait_timeout", 64'(target), 64'((sel == 0) ? n_rsp2 : n_rsp3));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},      64'(busy2),      64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready2), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid2), 64'd0);
        chk({tag, "_rsp_data"},  64'(rsp_data2),  64'd0);
        chk({tag, "_rsp_zero"},  64'(rsp_zero2),  64'd0);
        chk({tag, "_alu_ctl"},   64'(alu_ctl2),   64'd0);
        chk({tag, "_alu_a"},     64'(alu_a2),     64'd0);
        chk({tag, "_alu_b"},     64'(alu_b2),     64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        req_valid2 = '0; ctl2 = '0; a2 = '0; b2 = '0; rsp_ready2 = 2'b11;
        req_valid3 = '0; ctl3 = '0; a3 = '0; b3 = '0; rsp_ready3 = 3'b111;

        // Reset state
        repeat (2) @(posedge clk);
        #1 chk_zero_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Single op: 5 + 7 on requester 0, two-cycle latency
        gq2.push_back(8'b01); rq2.push_back('{8'b01, 32'd12, 1'b0});
        ctl2[2:0] = 3'd0; a2[31:0] = 32'd5; b2[31:0] = 32'd7; req_valid2 = 2'b01;
        wait_grants(0, 1); #1 req_valid2 = 2'b00;
        chk("exec_busy",  64'(busy2),      64'd1);
        chk("exec_alu_a", 64'(alu_a2),     64'd5);
        chk("exec_alu_b", 64'(alu_b2),     64'd7);
        chk("exec_no_rv", 64'(rsp_valid2), 64'd0);
        @(posedge clk); #1;
        chk("lat_rsp_valid", 64'(rsp_valid2), 64'b01);
        wait_rsps(0, 1); #1;

        // Zero flag: 0x1234 - 0x1234 on requester 1
        gq2.push_back(8'b10); rq2.push_back('{8'b10, 32'd0, 1'b1});
        ctl2[5:3] = 3'd1; a2[63:32] = 32'h1234; b2[63:32] = 32'h1234; req_valid2 = 2'b10;
        wait_grants(0, 2); #1 req_valid2 = 2'b00;
        wait_rsps(0, 2); #1;

        // Reset during EXEC: no response, outputs cleared asynchronously
        gq2.push_back(8'b01);
        ctl2[2:0] = 3'd0; a2[31:0] = 32'd5; b2[31:0] = 32'd7; req_valid2 = 2'b01;
        wait_grants(0, 3); #1 req_valid2 = 2'b00;
        chk("midop_busy", 64'(busy2), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("midop");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midop_idle",   64'(busy2),      64'd0);
        chk("midop_no_rv",  64'(rsp_valid2), 64'd0);
        chk("midop_no_rsp", 64'(n_rsp2),     64'd2);

        // Round-robin with both requesters continuously valid
        ctl2 = {3'd1, 3'd0}; a2 = {32'd10, 32'd1}; b2 = {32'd3, 32'd2};
        for (int k = 0; k < 2; k++) begin
            gq2.push_back(8'b01); rq2.push_back('{8'b01, 32'd3, 1'b0});
            gq2.push_back(8'b10); rq2.push_back('{8'b10, 32'd7, 1'b0});
        end
        req_valid2 = 2'b11;
        for (int g = 1; g <= 4; g++) begin
            wait_grants(0, 3 + g); #1;
`ifdef ALU_ARB_STAT_EN
            chk("rr_contention", 64'(contention2), 64'd1);
`endif
            if (g == 4) req_valid2 = 2'b00;
        end
        wait_rsps(0, 6); #1;
`ifdef ALU_ARB_STAT_EN
        chk("rr_op_count", 64'(op_count2), 64'd4);
`endif

        // Backpressure: only the non-owner is ready for 5 cycles
        rsp_ready2 = 2'b10;
        gq2.push_back(8'b01); rq2.push_back('{8'b01, 32'h0000_F000, 1'b0});
        ctl2[2:0] = 3'd2; a2[31:0] = 32'h0000_F0F0; b2[31:0] = 32'h0000_FF00; req_valid2 = 2'b01;
        wait_grants(0, 8); #1;
        gq2.push_back(8'b10); rq2.push_back('{8'b10, 32'h5555_AAAA, 1'b0});
        ctl2[5:3] = 3'd4; a2[63:32] = 32'hAAAA_5555; b2[63:32] = 32'hFFFF_FFFF; req_valid2 = 2'b10;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", 64'(rsp_valid2), 64'b01);
            chk("bp_rsp_data",  64'(rsp_data2),  64'h0000_F000);
            chk("bp_rsp_zero",  64'(rsp_zero2),  64'd0);
            chk("bp_req_ready", 64'(req_ready2), 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready2 = 2'b01;
        @(posedge clk); #1;
        chk("bp_grant_after_hs", 64'(req_ready2), 64'b10);
        rsp_ready2 = 2'b11;
        wait_grants(0, 9); #1 req_valid2 = 2'b00;
        wait_rsps(0, 8); #1;

        // Wrap-around with NREQ=3: move rr_ptr to 2, then requesters 2 and 0 compete
        gq3.push_back(8'b010); rq3.push_back('{8'b010, 32'd101, 1'b0});
        ctl3[5:3] = 3'd0; a3[63:32] = 32'd100; b3[63:32] = 32'd1; req_valid3 = 3'b010;
        wait_grants(1, 1); #1 req_valid3 = 3'b000;
        ctl3[8:6] = 3'd1; a3[95:64] = 32'd50;     b3[95:64] = 32'd8;
        ctl3[2:0] = 3'd3; a3[31:0]  = 32'h0F00;   b3[31:0]  = 32'h00F0;
        gq3.push_back(8'b100); rq3.push_back('{8'b100, 32'd42,    1'b0});
        gq3.push_back(8'b001); rq3.push_back('{8'b001, 32'h0FF0,  1'b0});
        gq3.push_back(8'b100); rq3.push_back('{8'b100, 32'd42,    1'b0});
        req_valid3 = 3'b101;
        wait_grants(1, 4); #1 req_valid3 = 3'b000;
        wait_rsps(1, 4); #1;

        chk("sb_grant2_drained", 64'(gq2.size()), 64'd0);
        chk("sb_rsp2_drained",   64'(rq2.size()), 64'd0);
        chk("sb_grant3_drained", 64'(gq3.size()), 64'd0);
        chk("sb_rsp3_drained",   64'(rq3.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
